// File: rtl/bsr_chain.sv
`default_nettype none
// ============================================================================
// Module      : bsr_chain
// Description : Parameterisable boundary-scan register chain. Each cell is
//               either an output cell (core -> pad) or an input cell
//               (pad -> core), selected by DIR_MASK. It has a capture/shift
//               register and an update register, and muxes pins and core
//               signals by mode (NORMAL / EXTEST / INTEST / CLAMP).
//               Optional shift-length checking is enabled by defining
//               BSR_SHIFT_CHECK_EN. Without it, shift_err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bsr_chain #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] DIR_MASK   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] SAFE_VALUE = {WIDTH{1'b0}}
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             capture_dr,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  logic [1:0]       mode,
    input  logic             scan_in,
    output logic             scan_out,
    input  logic [WIDTH-1:0] core_in,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] core_out,
    output logic             shift_err
);

    // Mode encoding. Bit 0 set means output cells drive the update register
    // (EXTEST, CLAMP). Bit 1 set means input cells drive the update register
    // (INTEST, CLAMP).
    localparam logic [1:0] c_MODE_NORMAL = 2'b00;
    localparam logic [1:0] c_MODE_EXTEST = 2'b01;
    localparam logic [1:0] c_MODE_INTEST = 2'b10;
    localparam logic [1:0] c_MODE_CLAMP  = 2'b11;

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_upd;
    logic [WIDTH-1:0] w_par;
    logic             w_out_sel;
    logic             w_in_sel;

    assign w_out_sel = (mode == c_MODE_EXTEST) || (mode == c_MODE_CLAMP);
    assign w_in_sel  = (mode == c_MODE_INTEST) || (mode == c_MODE_CLAMP);

    // Per-cell parallel capture source and pin/core muxing.
    // The direction of each cell is fixed at elaboration.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            if (DIR_MASK[gi]) begin : g_out_cell
                assign w_par[gi]    = core_in[gi];
                assign pin_out[gi]  = w_out_sel ? r_upd[gi] : core_in[gi];
                assign core_out[gi] = 1'b0;
            end else begin : g_in_cell
                assign w_par[gi]    = pin_in[gi];
                assign core_out[gi] = w_in_sel ? r_upd[gi] : pin_in[gi];
                assign pin_out[gi]  = 1'b0;
            end
        end
    endgenerate

    // Capture/shift register. Capture wins over shift.
    // Shifting moves the register toward bit 0, and scan_in enters at the MSB.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            r_shift <= '0;
        end else if (capture_dr) begin
            r_shift <= w_par;
        end else if (shift_dr) begin
            if (WIDTH == 1) begin
                r_shift <= scan_in;
            end else begin
                r_shift <= {scan_in, r_shift[WIDTH-1:1]};
            end
        end
    end

    // Update register. It samples the pre-edge shift value, so a capture or
    // shift on the same edge does not affect the value loaded.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            r_upd <= SAFE_VALUE;
        end else if (update_dr) begin
            r_upd <= r_shift;
        end
    end

    assign scan_out = r_shift[0];

`ifdef BSR_SHIFT_CHECK_EN
    // The counter has one extra bit of headroom. Saturation then keeps a
    // long over-shift from wrapping back to exactly WIDTH.
    localparam int                 c_CNT_W = $clog2(WIDTH + 1) + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_MAX   = {c_CNT_W{1'b1}};

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    // Count shift-only edges since the last capture or update.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            r_cnt <= '0;
        end else if (capture_dr || update_dr) begin
            r_cnt <= '0;
        end else if (shift_dr && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Flag an update whose preceding shift length was not exactly WIDTH.
    // The flag lasts one cycle.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            r_err <= 1'b0;
        end else begin
            r_err <= update_dr && (r_cnt != c_FULL);
        end
    end

    assign shift_err = r_err;
`else
    assign shift_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsr_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsr_chain
// Description : Scoreboard bench for bsr_chain with WIDTH=8, DIR_MASK=8'hF0
//               and SAFE_VALUE=8'h00. Output cells are the high nibble and
//               input cells are the low nibble. The shift-error expectations
//               follow BSR_SHIFT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsr_chain;

    localparam int         c_W    = 8;
    localparam logic [7:0] c_MASK = 8'hF0;
    localparam logic [7:0] c_SAFE = 8'h00;

    logic       TCK = 1'b0;
    logic       TRST, capture_dr, shift_dr, update_dr, scan_in;
    logic [1:0] mode;
    logic [7:0] core_in, pin_in, pin_out, core_out;
    logic       scan_out, shift_err;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entries: {pin_out, core_out}, or a single bit in [0].
    logic [15:0] exp_q [$];
    logic [15:0] e;

    bsr_chain #(.WIDTH(c_W), .DIR_MASK(c_MASK), .SAFE_VALUE(c_SAFE)) dut (
        .TCK(TCK), .TRST(TRST), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .mode(mode), .scan_in(scan_in),
        .scan_out(scan_out), .core_in(core_in), .pin_in(pin_in),
        .pin_out(pin_out), .core_out(core_out), .shift_err(shift_err)
    );

    always #5 TCK = ~TCK;

    task automatic step();
        @(posedge TCK);
        #1;
    endtask

    task automatic test_reset();
        TRST = 1'b1; core_in = 8'hFF; pin_in = 8'hFF; mode = 2'b00;
        step(); step();
        TRST = 1'b0;
        exp_q.push_back(16'h0);
        exp_q.push_back(16'hF00F);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h000F);
        e = exp_q.pop_front();
        n_checks++;
        if ({scan_out, shift_err} !== e[1:0]) begin
            n_errors++;
            $display("FAIL reset_regs got scan_out=%b shift_err=%b exp 0 0", scan_out, shift_err);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({pin_out, core_out} !== e) begin
            n_errors++;
            $display("FAIL reset_normal got %h/%h exp %h", pin_out, core_out, e);
        end
        mode = 2'b11; #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({pin_out, core_out} !== e) begin
            n_errors++;
            $display("FAIL reset_clamp got %h/%h exp %h", pin_out, core_out, e);
        end
        mode = 2'b01; #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({pin_out, core_out} !== e) begin
            n_errors++;
            $display("FAIL reset_extest got %h/%h exp %h", pin_out, core_out, e);
        end
        mode = 2'b00;
    endtask

    task automatic test_capture_shift();
        logic [7:0] p;
        core_in = 8'hA0; pin_in = 8'h05; scan_in = 1'b0;
        p = 8'hA5;
        for (int i = 0; i < 8; i++) exp_q.push_back({15'h0, p[i]});
        for (int i = 0; i < 8; i++) begin
            if (i == 0) capture_dr = 1'b1; else shift_dr = 1'b1;
            step();
            capture_dr = 1'b0; shift_dr = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (scan_out !== e[0]) begin
                n_errors++;
                $display("FAIL cap_shift bit%0d got %b exp %b", i, scan_out, e[0]);
            end
        end
    endtask

    task automatic test_update_modes();
        logic [7:0]  v;
        logic [1:0]  modes [4];
        logic [15:0] outs  [4];
        v = 8'h3C;
        modes = '{2'b01, 2'b10, 2'b11, 2'b00};
        outs  = '{16'h3005, 16'hA00C, 16'h300C, 16'hA005};
        for (int i = 0; i < 8; i++) begin
            scan_in = v[i]; shift_dr = 1'b1;
            step();
        end
        shift_dr = 1'b0;
        update_dr = 1'b1;
        step();
        update_dr = 1'b0;
        core_in = 8'hA0; pin_in = 8'h05;
        for (int i = 0; i < 4; i++) exp_q.push_back(outs[i]);
        for (int i = 0; i < 4; i++) begin
            mode = modes[i]; #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({pin_out, core_out} !== e) begin
                n_errors++;
                $display("FAIL upd_mode%0d got %h/%h exp %h", modes[i], pin_out, core_out, e);
            end
        end
    endtask

    task automatic test_priority();
        mode = 2'b11;
        core_in = 8'h30; pin_in = 8'h0C; scan_in = 1'b1;
        capture_dr = 1'b1; shift_dr = 1'b1;
        step();
        capture_dr = 1'b0; shift_dr = 1'b0;
        update_dr = 1'b1;
        step();
        update_dr = 1'b0;
        exp_q.push_back(16'h300C);
        e = exp_q.pop_front();
        n_checks++;
        if ({pin_out, core_out} !== e) begin
            n_errors++;
            $display("FAIL cap_over_shift got %h/%h exp %h", pin_out, core_out, e);
        end
        core_in = 8'h50; pin_in = 8'h0A;
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        update_dr = 1'b1; shift_dr = 1'b1; scan_in = 1'b1;
        step();
        update_dr = 1'b0; shift_dr = 1'b0;
        exp_q.push_back(16'h500A);
        exp_q.push_back(16'h0001);
        e = exp_q.pop_front();
        n_checks++;
        if ({pin_out, core_out} !== e) begin
            n_errors++;
            $display("FAIL upd_preshift got %h/%h exp %h", pin_out, core_out, e);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (scan_out !== e[0]) begin
            n_errors++;
            $display("FAIL shift_with_upd got %b exp %b", scan_out, e[0]);
        end
        mode = 2'b00;
    endtask

    task automatic test_reset_mid_shift();
        core_in = 8'hFF; pin_in = 8'hFF; scan_in = 1'b1;
        capture_dr = 1'b1; step(); capture_dr = 1'b0;
        update_dr = 1'b1; step(); update_dr = 1'b0;
        mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            shift_dr = 1'b1; step();
        end
        TRST = 1'b1;
        step();
        TRST = 1'b0; shift_dr = 1'b0;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        e = exp_q.pop_front();
        n_checks++;
        if ({7'h0, scan_out} !== e[7:0]) begin
            n_errors++;
            $display("FAIL rst_mid_scan got %b exp 0", scan_out);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({pin_out, core_out} !== e) begin
            n_errors++;
            $display("FAIL rst_mid_clamp got %h/%h exp %h", pin_out, core_out, e);
        end
        mode = 2'b00;
    endtask

    task automatic test_shift_check();
        int n_sh [2];
        n_sh = '{7, 8};
        scan_in = 1'b0; mode = 2'b00;
        for (int k = 0; k < 2; k++) begin
            capture_dr = 1'b1; step(); capture_dr = 1'b0;
            for (int i = 0; i < n_sh[k]; i++) begin
                shift_dr = 1'b1; step();
            end
            shift_dr = 1'b0;
            update_dr = 1'b1;
`ifdef BSR_SHIFT_CHECK_EN
            exp_q.push_back({15'h0, (n_sh[k] != 8)});
`else
            exp_q.push_back(16'h0);
`endif
            exp_q.push_back(16'h0);
            step();
            update_dr = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (shift_err !== e[0]) begin
                n_errors++;
                $display("FAIL shift_err_%0d got %b exp %b", n_sh[k], shift_err, e[0]);
            end
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (shift_err !== e[0]) begin
                n_errors++;
                $display("FAIL shift_err_%0d_next got %b exp %b", n_sh[k], shift_err, e[0]);
            end
        end
    endtask

    initial begin
        TRST = 1'b1; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        scan_in = 1'b0; mode = 2'b00; core_in = '0; pin_in = '0;
        test_reset();
        test_capture_shift();
        test_update_modes();
        test_priority();
        test_reset_mid_shift();
        test_shift_check();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsr_chain.md
BSR_CHAIN -- requirements
Module: bsr_chain

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the number of boundary cells (legal range 1..64).
REQ-002 The module SHALL have parameter DIR_MASK, WIDTH bits, default all ones; bit i=1 makes cell i an output cell, 0 an input cell.
REQ-003 The module SHALL have parameter SAFE_VALUE, WIDTH bits, default 0, giving the update-register reset value.
REQ-004 The module SHALL have port TCK, input, 1 bit, as the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port TRST, input, 1 bit, as the reset, which is synchronous and active-high.
REQ-006 The module SHALL have ports capture_dr, shift_dr and update_dr, each input, 1 bit, as synchronous enables sampled on TCK.
REQ-007 The module SHALL have port mode, input, 2 bits: 00 NORMAL, 01 EXTEST, 10 INTEST, 11 CLAMP.
REQ-008 The module SHALL have ports scan_in, input, 1 bit, and scan_out, output, 1 bit, as the serial chain.
REQ-009 The module SHALL have ports core_in, input, WIDTH bits (core to output cells), and pin_in, input, WIDTH bits (pad to input cells).
REQ-010 The module SHALL have ports pin_out, output, WIDTH bits (to pads), and core_out, output, WIDTH bits (to core).
REQ-011 The module SHALL have port shift_err, output, 1 bit, as a shift-length error pulse.

Function
REQ-012 Cell i SHALL take parallel input p[i] = core_in[i] when DIR_MASK[i]=1, else pin_in[i].
REQ-013 Each edge with capture_dr=1 SHALL load the shift register with p[WIDTH-1:0].
REQ-014 Each edge with capture_dr=0 and shift_dr=1 SHALL shift the register right by one: scan_in enters bit WIDTH-1 and bit 0 is discarded.
REQ-015 When capture_dr and shift_dr are both 1 on the same edge, capture SHALL take priority.
REQ-016 scan_out SHALL equal shift-register bit 0 (registered), so bit 0 appears before any shift and each following bit one edge after each shift.
REQ-017 Each edge with update_dr=1 SHALL load the update register with the pre-edge shift-register value; a same-edge capture or shift does not affect the loaded value.
REQ-018 For an output cell, pin_out[i] SHALL be upd[i] when mode is EXTEST or CLAMP, else core_in[i]; core_out[i] SHALL be 0.
REQ-019 For an input cell, core_out[i] SHALL be upd[i] when mode is INTEST or CLAMP, else pin_in[i]; pin_out[i] SHALL be 0.
REQ-020 pin_out and core_out SHALL be combinational from mode, upd and the inputs, so a mode change takes effect with zero cycles of latency.
REQ-021 With no enables asserted, all registers SHALL hold their values.

Reset
REQ-022 While TRST=1 at a TCK edge, the shift register SHALL be cleared to 0, the update register set to SAFE_VALUE, the shift counter cleared and shift_err driven to 0; TRST overrides all enables.
REQ-023 Reset asserted mid-shift SHALL discard partial data; scan_out SHALL be 0 on the edge after reset.
REQ-024 Directly after reset in NORMAL mode, all pins and core outputs SHALL be transparent; in EXTEST or CLAMP mode, outputs SHALL show SAFE_VALUE.

Configuration
REQ-025 With BSR_SHIFT_CHECK_EN defined, a saturating shift counter of width clog2(WIDTH+1)+1 SHALL be cleared on capture, incremented on each shift-only edge, and cleared on update.
REQ-026 With BSR_SHIFT_CHECK_EN defined, an update_dr edge with count != WIDTH SHALL assert shift_err for exactly the following cycle; the update register still loads.
REQ-027 Without BSR_SHIFT_CHECK_EN defined, no counter SHALL be implemented and shift_err SHALL be tied to 0; the port list is unchanged.

Verification (WIDTH=8, DIR_MASK=8'hF0, SAFE_VALUE=8'h00)
REQ-028 The bench SHALL check: core_in=8'hA0, pin_in=8'h05, capture, then 8 shifts -> scan_out sequence LSB-first 1,0,1,0,0,1,0,1.
REQ-029 The bench SHALL check: shift in 8'h3C LSB-first, update, mode=EXTEST -> pin_out=8'h30; mode=INTEST -> core_out=8'h0C; mode=NORMAL -> pin_out=core_in[7:4] in the high nibble.
REQ-030 The bench SHALL check: capture_dr=shift_dr=1 on the same edge -> register equals p and no shift occurs; update_dr with shift on the same edge -> upd equals the pre-shift value.
REQ-031 The bench SHALL check: TRST=1 after 4 of 8 shifts with mode=CLAMP -> scan_out=0, pin_out=0 and core_out=0 next cycle.
REQ-032 The bench SHALL check, with BSR_SHIFT_CHECK_EN defined: capture, 7 shifts, update -> shift_err=1 for one cycle; with 8 shifts -> shift_err stays 0.
REQ-033 The bench SHALL check, without BSR_SHIFT_CHECK_EN defined: the same 7-shift sequence -> shift_err stays 0.
